// File: rtl/vc_pop_scheduler.sv
// vc_pop_scheduler: drains two first-word-fall-through virtual-channel FIFOs
// (VC0, VC1) into two destination FIFOs (D0, D1). Arbitrates between the VCs
// with latched burst quotas, routes each word by its destination bit and
// honours destination almost-full backpressure.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   init                       enable; quotas latched on IDLE -> SERVE0
//   quota_vc0, quota_vc1       burst quotas (0 is treated as 1)
//   vc0_empty, vc1_empty       VC FIFO empty flags
//   vc0_data, vc1_data         VC FIFO head words
//   d0_almost_full, d1_almost_full  destination backpressure
//   vc0_pop, vc1_pop           combinational pop strobes (one-hot or zero)
//   d0_push, d1_push           registered push strobes
//   data_out                   registered word to the destination FIFOs
//   active                     registered, high while serving
//   stall_count                (VC_POP_SCHEDULER_STALL_COUNT_EN only) saturating
//                              count of serving cycles with data but no pop
//
// Optional feature macro: VC_POP_SCHEDULER_STALL_COUNT_EN
module vc_pop_scheduler #(
    parameter int unsigned data_width  = 6,
    parameter int unsigned quota_width = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [quota_width-1:0] quota_vc0,
    input  logic [quota_width-1:0] quota_vc1,
    input  logic                   vc0_empty,
    input  logic                   vc1_empty,
    input  logic [data_width-1:0]  vc0_data,
    input  logic [data_width-1:0]  vc1_data,
    input  logic                   d0_almost_full,
    input  logic                   d1_almost_full,
    output logic                   vc0_pop,
    output logic                   vc1_pop,
    output logic                   d0_push,
    output logic                   d1_push,
    output logic [data_width-1:0]  data_out,
    output logic                   active
`ifdef VC_POP_SCHEDULER_STALL_COUNT_EN
    ,
    output logic [7:0]             stall_count
`endif
);

    localparam int unsigned dest_bit = data_width - 2;

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_serve0 = 2'd1;
    localparam logic [1:0] st_serve1 = 2'd2;

    logic [1:0]             state_q,    state_d;
    logic [quota_width-1:0] cnt_q,      cnt_d;
    logic [quota_width-1:0] quota0_q,   quota0_d;
    logic [quota_width-1:0] quota1_q,   quota1_d;
    logic [data_width-1:0]  data_out_q, data_out_d;
    logic                   d0_push_q,  d0_push_d;
    logic                   d1_push_q,  d1_push_d;
    logic                   active_q,   active_d;

    logic                   elig0_c;
    logic                   elig1_c;
    logic [quota_width-1:0] cnt_inc_c;
    logic [data_width-1:0]  pop_word_c;
    logic                   pop_any_c;

    // A VC is eligible when it has a head word whose destination can accept it
    assign elig0_c   = !vc0_empty && !(vc0_data[dest_bit] ? d1_almost_full : d0_almost_full);
    assign elig1_c   = !vc1_empty && !(vc1_data[dest_bit] ? d1_almost_full : d0_almost_full);
    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + quota_width'(1);

    // Next-state, arbitration and push datapath
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quota0_d   = quota0_q;
        quota1_d   = quota1_q;
        vc0_pop    = 1'b0;
        vc1_pop    = 1'b0;

        case (state_q)
            st_idle: begin
                if (init) begin
                    state_d  = st_serve0;
                    cnt_d    = '0;
                    quota0_d = (quota_vc0 == '0) ? quota_width'(1) : quota_vc0;
                    quota1_d = (quota_vc1 == '0) ? quota_width'(1) : quota_vc1;
                end
            end
            st_serve0: begin
                if (!init) begin
                    state_d = st_idle;
                end else if (elig0_c && ((cnt_q < quota0_q) || !elig1_c)) begin
                    vc0_pop = 1'b1;
                    cnt_d   = cnt_inc_c;
                end else if (elig1_c) begin
                    vc1_pop = 1'b1;
                    state_d = st_serve1;
                    cnt_d   = quota_width'(1);
                end
            end
            st_serve1: begin
                if (!init) begin
                    state_d = st_idle;
                end else if (elig1_c && ((cnt_q < quota1_q) || !elig0_c)) begin
                    vc1_pop = 1'b1;
                    cnt_d   = cnt_inc_c;
                end else if (elig0_c) begin
                    vc0_pop = 1'b1;
                    state_d = st_serve0;
                    cnt_d   = quota_width'(1);
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase

        pop_any_c  = vc0_pop || vc1_pop;
        pop_word_c = vc0_pop ? vc0_data : vc1_data;
        d0_push_d  = pop_any_c && !pop_word_c[dest_bit];
        d1_push_d  = pop_any_c &&  pop_word_c[dest_bit];
        data_out_d = pop_any_c ? pop_word_c : data_out_q;
        active_d   = (state_d == st_serve0) || (state_d == st_serve1);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= st_idle;
            cnt_q      <= '0;
            quota0_q   <= quota_width'(1);
            quota1_q   <= quota_width'(1);
            data_out_q <= '0;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quota0_q   <= quota0_d;
            quota1_q   <= quota1_d;
            data_out_q <= data_out_d;
            d0_push_q  <= d0_push_d;
            d1_push_q  <= d1_push_d;
            active_q   <= active_d;
        end
    end

    assign d0_push  = d0_push_q;
    assign d1_push  = d1_push_q;
    assign data_out = data_out_q;
    assign active   = active_q;

`ifdef VC_POP_SCHEDULER_STALL_COUNT_EN
    logic [7:0] stall_q, stall_d;
    logic       stall_c;

    // A stall is a serving cycle with data waiting but nothing popped,
    // which includes the cycle in which init drops
    assign stall_c = ((state_q == st_serve0) || (state_q == st_serve1)) &&
                     (!vc0_empty || !vc1_empty) && !vc0_pop && !vc1_pop;

    always_comb begin
        stall_d = stall_q;
        if (stall_c && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: doc/vc_pop_scheduler.md
Name: vc_pop_scheduler

Overview:
- Sequences draining of the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1) of the transmission logic.
- Arbitrates VC0/VC1 with programmable burst quotas and routes each word by its destination bit.
- Honours destination almost-full backpressure.
- Sits between the VC FIFO outputs and the D FIFO write ports; VC FIFOs are first-word-fall-through (head valid whenever not empty).

Parameters:
- data_width, 6, word width; bit [data_width-2] selects destination (0 = D0, 1 = D1).
- quota_width, 4, width of burst quota inputs and burst counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  enable; quotas are latched when leaving IDLE.
- quota_vc0  input  quota_width  max consecutive VC0 pops while VC1 is pending.
- quota_vc1  input  quota_width  max consecutive VC1 pops while VC0 is pending.
- vc0_empty, vc1_empty  input  1  VC FIFO empty flags.
- vc0_data, vc1_data  input  data_width  VC FIFO head words.
- d0_almost_full, d1_almost_full  input  1  destination FIFO almost-full flags.
- vc0_pop, vc1_pop  output  1  combinational pop strobes.
- d0_push, d1_push  output  1  registered push strobes.
- data_out  output  data_width  registered word to the D FIFOs.
- active  output  1  registered; high when the FSM is in SERVE0 or SERVE1.

Behaviour:
- Reset: state=IDLE, burst counter=0, latched quotas=1, all outputs 0. Reset mid-operation drops any word not yet pushed; the VC FIFO already popped it, which is accepted loss.
- States:
  - IDLE: no pops. On init=1, go to SERVE0, latch quotas (a quota of 0 is treated as 1), and clear the counter.
  - SERVE0 / SERVE1: serve the indicated VC.
  - In any serving state, init=0 returns to IDLE at the next edge and blocks pops in that cycle.
- Eligibility (combinational): VCx is eligible when it is not empty and the D FIFO selected by its head bit [data_width-2] is not almost full.
- Pop decision each cycle in SERVEx, with y the other VC:
  - If VCx is eligible and (counter < quota_x, or VCy is not eligible): pop VCx and increment the counter, saturating at max.
  - Else if VCy is eligible: pop VCy, move to SERVEy, and set the counter to 1.
  - Else: no pop; state and counter hold.
- At most one pop per cycle; vc0_pop and vc1_pop are never both high.
- A quota only limits VCx while VCy is eligible. With VCy idle or blocked, VCx streams indefinitely.
- Datapath latency is 1 cycle:
  - At the edge after a pop, data_out takes the popped word.
  - In that same cycle exactly one of d0_push/d1_push is high, per the word's bit [data_width-2].
  - Push strobes are 0 in cycles following no pop; data_out holds its last value.
- Backpressure margin: because of the 1-cycle latency, D almost-full thresholds must leave at least 1 free entry. The block does not check this.
- Quota inputs changing while in a serving state are ignored until the next IDLE→SERVE0 transition.

Optional Feature:
- Macro: VC_POP_SCHEDULER_STALL_COUNT_EN
- Defined:
  - Adds output stall_count (8 bits, registered, reset 0).
  - Increments by 1 on every serving-state cycle where at least one VC is non-empty but no pop occurs. This covers both the destination-blocked case and the init-drop cycle.
  - Saturates at 255; cleared only by reset.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset/IDLE: reset=1 for 2 cycles, both VCs non-empty, init=0 → no pops, all outputs 0, active=0.
- Quota alternation: quota_vc0=2, quota_vc1=1, both VCs hold ≥6 words with bit4=0, no almost-full, init=1 → pop order VC0,VC0,VC1,VC0,VC0,VC1; d0_push pulses one cycle after each pop, data_out matching each head.
- Routing: VC0 words 6'b000101 then 6'b010100, VC1 empty → d0_push with 000101, then d1_push with 010100 on consecutive cycles.
- Backpressure switch: VC0 head 6'b010110, d1_almost_full=1, VC1 head 6'b000110 → VC1 popped, state SERVE1. Release d1_almost_full → VC0 resumes once VC1's quota is exhausted or VC1 is empty.
- Full stall: both heads target D1, d1_almost_full=1 for 5 cycles → no pops for 5 cycles. With the macro defined, stall_count=5. Zero quota: quota_vc0=0 → behaves as quota 1.
- init drop mid-stream: init 1→0 while both VCs are non-empty → pops stop in that cycle, state IDLE next edge, active=0. Raising init again → latches the new quotas and starts in SERVE0.
